// File: rtl/key_press_conditioner_if.sv
// Signal bundle between the key conditioner and its consumer: raw keys and
// repeat enables in, registered per-key event pulses and FSM state out.
interface key_press_conditioner_if #(
    parameter int N_KEYS = 4
);
    // There is no back-pressure: each *_pulse bit is a self-qualifying
    // one-cycle strobe that the consumer must take on the cycle it is high.
    logic [N_KEYS-1:0]   KEY;
    logic [N_KEYS-1:0]   repeat_en;
    logic [N_KEYS-1:0]   press_pulse;
    logic [N_KEYS-1:0]   step_pulse;
    logic [N_KEYS-1:0]   release_pulse;
    logic [N_KEYS-1:0]   held;
    logic [2*N_KEYS-1:0] fsm_state;

    modport master (
        output KEY,
        output repeat_en,
        input  press_pulse,
        input  step_pulse,
        input  release_pulse,
        input  held,
        input  fsm_state
    );

    modport slave (
        input  KEY,
        input  repeat_en,
        output press_pulse,
        output step_pulse,
        output release_pulse,
        output held,
        output fsm_state
    );
endinterface

// File: rtl/key_press_conditioner.sv
// Per-key synchronizer, debouncer and press/hold/auto-repeat FSM that turns
// raw active-low push buttons into clean one-cycle event pulses.
module key_press_conditioner #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    key_press_conditioner_if.slave  bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_KEYS-1:0]   press_vec;
    logic [N_KEYS-1:0]   step_vec;
    logic [N_KEYS-1:0]   release_vec;
    logic [N_KEYS-1:0]   held_vec;
    logic [2*N_KEYS-1:0] state_vec;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic          sync1_q;
        logic          sync2_q;
        logic          stable_q;
        logic          stable_d;
        logic [DW-1:0] dcnt_q;
        logic [DW-1:0] dcnt_d;
        state_t        state_q;
        state_t        state_d;
        logic [TW-1:0] timer_q;
        logic [TW-1:0] timer_d;
        logic          press_q;
        logic          press_d;
        logic          step_q;
        logic          step_d;
        logic          rel_q;
        logic          rel_d;
        logic          held_q;
        logic          pressed;

        // Synchronizer resets to the released level so reset never looks like a press.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= bus.KEY[k];
                sync2_q <= sync1_q;
            end
        end

        // A level change is accepted only after DEBOUNCE_CYC disagreeing cycles in a row.
        always_comb begin
            stable_d = stable_q;
            dcnt_d   = '0;
            if (sync2_q != stable_q) begin
                if (dcnt_q == DEB_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                stable_q <= 1'b1;
                dcnt_q   <= '0;
            end else begin
                stable_q <= stable_d;
                dcnt_q   <= dcnt_d;
            end
        end

        assign pressed = ~stable_q;

        // Release wins over timer expiry; dropping repeat_en parks the timer at zero.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            press_d = 1'b0;
            step_d  = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (pressed) begin
                        state_d = ST_HOLD;
                        press_d = 1'b1;
                        step_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!pressed) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                        timer_d = '0;
                    end else if (!bus.repeat_en[k]) begin
                        timer_d = '0;
                    end else if (timer_q == HOLD_LAST) begin
                        state_d = ST_REPEAT;
                        step_d  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!pressed) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                        timer_d = '0;
                    end else if (!bus.repeat_en[k]) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else if (timer_q == REP_LAST) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                press_q <= 1'b0;
                step_q  <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                press_q <= press_d;
                step_q  <= step_d;
                rel_q   <= rel_d;
                held_q  <= (state_d != ST_IDLE);
            end
        end

        assign press_vec[k]        = press_q;
        assign step_vec[k]         = step_q;
        assign release_vec[k]      = rel_q;
        assign held_vec[k]         = held_q;
        assign state_vec[2*k +: 2] = state_q;
    end

    assign bus.press_pulse   = press_vec;
    assign bus.step_pulse    = step_vec;
    assign bus.release_pulse = release_vec;
    assign bus.held          = held_vec;
    assign bus.fsm_state     = state_vec;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: directed scenarios plus random key bouncing,
// checked by a cycle-stamped expected-event queue fed by a behavioural model.
module tb_key_press_conditioner;
    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int PW   = 3 * N;
    localparam int W    = 32 + PW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_press_conditioner_if #(.N_KEYS(N)) bus ();

    key_press_conditioner #(
        .N_KEYS       (N),
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (REP)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    logic [N-1:0] exp_held;

    // Model: raw level two edges late, accepted level, run of disagreement,
    // whether the key is down, and the edge from which repeat timing counts.
    logic hist0 [N];
    logic hist1 [N];
    logic acc   [N];
    int   run   [N];
    logic down  [N];
    int   anchor[N];

    // Observations of what the DUT actually emitted.
    int           press_cnt [N];
    int           step_cnt  [N];
    int           rel_cnt   [N];
    int           last_press[N];
    int           last_rel  [N];
    logic [N-1:0] last_press_vec;
    int           step2_q[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            hist0[k]  = 1'b1;
            hist1[k]  = 1'b1;
            acc[k]    = 1'b1;
            run[k]    = 0;
            down[k]   = 1'b0;
            anchor[k] = 0;
        end
        exp_held = '0;
        exp_q.delete();
    endtask

    // Outputs after edge n depend on the accepted level from edge n-1; steps
    // fall at anchor+HOLD+j*REP while the key stays down with repeat enabled.
    task automatic model_step();
        logic [N-1:0] pv, sv, rv;
        int el;
        pv = '0; sv = '0; rv = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < N; k++) begin
            if (!acc[k] && !down[k]) begin
                pv[k] = 1'b1; sv[k] = 1'b1; down[k] = 1'b1; anchor[k] = cyc;
            end else if (acc[k] && down[k]) begin
                rv[k] = 1'b1; down[k] = 1'b0;
            end else if (down[k]) begin
                if (!bus.repeat_en[k]) begin
                    anchor[k] = cyc;
                end else begin
                    el = cyc - anchor[k];
                    if (el >= HOLD && ((el - HOLD) % REP) == 0) sv[k] = 1'b1;
                end
            end
            exp_held[k] = down[k];
            if (hist1[k] != acc[k]) begin
                run[k]++;
                if (run[k] == DEB) begin
                    acc[k] = hist1[k];
                    run[k] = 0;
                end
            end else begin
                run[k] = 0;
            end
            hist1[k] = hist0[k];
            hist0[k] = bus.KEY[k];
        end
        if ((pv | sv | rv) != '0) exp_q.push_back({32'(cyc), pv, sv, rv});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Monitor: pops one expectation whenever the DUT emits any pulse.
    initial begin
        logic [PW-1:0] got;
        logic [W-1:0]  e;
        int            ecyc;
        forever begin
            @(negedge clk);
            got = {bus.press_pulse, bus.step_pulse, bus.release_pulse};
            while (exp_q.size() > 0) begin
                e    = exp_q[0];
                ecyc = int'(e[W-1:PW]);
                if (ecyc >= cyc) break;
                checks++;
                errors++;
                $display("FAIL missed_pulse: expected %h at cycle %0d was not emitted", e[PW-1:0], ecyc);
                void'(exp_q.pop_front());
            end
            if (got != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got %h at cycle %0d, expected none", got, cyc);
                end else begin
                    e    = exp_q.pop_front();
                    ecyc = int'(e[W-1:PW]);
                    if (ecyc != cyc || e[PW-1:0] !== got) begin
                        errors++;
                        $display("FAIL pulse: got %h at cycle %0d, expected %h at cycle %0d",
                                 got, cyc, e[PW-1:0], ecyc);
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (bus.press_pulse[k]) begin
                        press_cnt[k]++;
                        last_press[k]  = cyc;
                        last_press_vec = bus.press_pulse;
                    end
                    if (bus.step_pulse[k]) begin
                        step_cnt[k]++;
                        if (k == 2) step2_q.push_back(cyc);
                    end
                    if (bus.release_pulse[k]) begin
                        rel_cnt[k]++;
                        last_rel[k] = cyc;
                    end
                end
            end
            checks++;
            if (bus.held !== exp_held) begin
                errors++;
                $display("FAIL held: got %b, expected %b (cycle %0d)", bus.held, exp_held, cyc);
            end
        end
    end

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_press",   int'(bus.press_pulse),   0);
        check("rst_step",    int'(bus.step_pulse),    0);
        check("rst_release", int'(bus.release_pulse), 0);
        check("rst_held",    int'(bus.held),          0);
        wait_cycles(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, t1, p0, p3, s3, r3, s1, r1, nexp, cnt;
        int dur[N];
        for (int k = 0; k < N; k++) begin
            press_cnt[k] = 0; step_cnt[k] = 0; rel_cnt[k] = 0;
            last_press[k] = -1; last_rel[k] = -1;
        end
        last_press_vec = '0;
        bus.KEY       = '1;
        bus.repeat_en = '0;
        model_reset();
        wait_cycles(4);
        check("reset_press",   int'(bus.press_pulse),   0);
        check("reset_step",    int'(bus.step_pulse),    0);
        check("reset_release", int'(bus.release_pulse), 0);
        check("reset_held",    int'(bus.held),          0);
        rst_n = 1'b1;
        wait_cycles(5);

        // T1: clean press on key 0
        t0 = cyc; p0 = press_cnt[0];
        bus.KEY[0] = 1'b0;
        wait_cycles(15);
        bus.KEY[0] = 1'b1;
        wait_cycles(30);
        check("t1_press_cycle",   last_press[0], t0 + 11);
        check("t1_press_count",   press_cnt[0] - p0, 1);
        check("t1_release_cycle", last_rel[0], t0 + 15 + 11);

        // T2: key 1 bouncing faster than the debounce window
        p0 = press_cnt[1]; s1 = step_cnt[1]; r1 = rel_cnt[1];
        for (int i = 0; i < 10; i++) begin
            bus.KEY[1] = ~bus.KEY[1];
            wait_cycles(3);
        end
        bus.KEY[1] = 1'b1;
        wait_cycles(30);
        check("t2_press_count",   press_cnt[1] - p0, 0);
        check("t2_step_count",    step_cnt[1] - s1,  0);
        check("t2_release_count", rel_cnt[1] - r1,   0);

        // T3: auto-repeat on key 2
        bus.repeat_en[2] = 1'b1;
        step2_q.delete();
        t0 = cyc;
        bus.KEY[2] = 1'b0;
        wait_cycles(11 + 60);
        bus.KEY[2] = 1'b1;
        wait_cycles(30);
        nexp = 1;
        for (int t = t0 + 11 + HOLD; t < t0 + 71 + 11; t += REP) nexp++;
        check("t3_step_count", step2_q.size(), nexp);
        check("t3_step0", (step2_q.size() > 0) ? step2_q[0] : -1, t0 + 11);
        check("t3_step1", (step2_q.size() > 1) ? step2_q[1] : -1, t0 + 31);
        check("t3_step2", (step2_q.size() > 2) ? step2_q[2] : -1, t0 + 36);
        check("t3_press_cycle",   last_press[2], t0 + 11);
        check("t3_release_cycle", last_rel[2], t0 + 71 + 11);

        // T4: key 3 held with repeat disabled
        bus.repeat_en[3] = 1'b0;
        t0 = cyc; s3 = step_cnt[3]; r3 = rel_cnt[3];
        bus.KEY[3] = 1'b0;
        wait_cycles(60);
        bus.KEY[3] = 1'b1;
        wait_cycles(30);
        check("t4_step_count",    step_cnt[3] - s3, 1);
        check("t4_release_count", rel_cnt[3] - r3,  1);
        check("t4_release_cycle", last_rel[3], t0 + 60 + 11);

        // T5: keys 0 and 3 together
        t0 = cyc; p0 = press_cnt[0]; p3 = press_cnt[3];
        bus.KEY[0] = 1'b0; bus.KEY[3] = 1'b0;
        wait_cycles(20);
        bus.KEY[0] = 1'b1; bus.KEY[3] = 1'b1;
        wait_cycles(30);
        check("t5_press_vec",   int'(last_press_vec), 9);
        check("t5_press_cycle", last_press[3], t0 + 11);
        check("t5_press_count", (press_cnt[0] - p0) + (press_cnt[3] - p3), 2);

        // T6: reset while key 2 is auto-repeating, key still held afterwards
        bus.repeat_en[2] = 1'b1;
        bus.KEY[2] = 1'b0;
        wait_cycles(11 + HOLD + 3);
        do_reset(3);
        t1 = cyc;
        wait_cycles(20);
        check("t6_fresh_press", last_press[2], t1 + 11);
        bus.KEY[2] = 1'b1;
        wait_cycles(30);

        // Random bouncing, random repeat enables, one reset in the middle
        for (int k = 0; k < N; k++) dur[k] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                if (dur[k] == 0) begin
                    bus.KEY[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(5, 60);
                end else begin
                    dur[k]--;
                end
                if ($urandom_range(0, 31) == 0) bus.repeat_en[k] = ~bus.repeat_en[k];
            end
            if (i == 700) do_reset(2);
            else wait_cycles(1);
        end
        bus.KEY = '1;
        wait_cycles(40);
        cnt = exp_q.size();
        check("queue_drained", cnt, 0);
        check("idle_held", int'(bus.held), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
